conv2d_psum_accum_16: RTL and testbench

Accumulates 16 lanes of partial convolution sums across input-channel tiles, adds per-channel bias, and requantizes each lane to signed Q(DATA_WIDTH-FRAC_BITS-1).FRAC_BITS. It sits directly upstream of the 16-lane ReLU stage. It takes MAC-array partial sums in double-fraction format (product of two Q·FRAC_BITS operands). It emits one 16-lane requantized word per output pixel, with a valid/ready handshake.

---
 rtl/conv2d_psum_accum_16.sv | 128 ++++++++++++
 tb/tb_conv2d_psum_accum_16.sv | 290 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/conv2d_psum_accum_16.sv
// 16-lane partial-sum accumulator: sums input-channel tiles, adds bias once per pixel,
// then rounds, saturates and registers one requantized 16-lane word per output pixel.
module conv2d_psum_accum_16 #(
    parameter int FRAC_BITS  = 7,
    parameter int DATA_WIDTH = 14,
    parameter int PSUM_WIDTH = 32,
    parameter int ACC_WIDTH  = 38,
    parameter int TILE_W     = 7
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [TILE_W-1:0]        cfg_num_tiles,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [PSUM_WIDTH*16-1:0] psum_in,
    input  logic [DATA_WIDTH*16-1:0] bias_in,
    output logic [DATA_WIDTH*16-1:0] data_out,
    output logic                     valid,
    input  logic                     out_ready,
    output logic                     busy
);
    localparam int LANES = 16;
    localparam logic signed [ACC_WIDTH:0] HALF    = (ACC_WIDTH+1)'(2 ** (FRAC_BITS - 1));
    localparam logic signed [ACC_WIDTH:0] SAT_MAX = (ACC_WIDTH+1)'(2 ** (DATA_WIDTH - 1) - 1);
    localparam logic signed [ACC_WIDTH:0] SAT_MIN = (ACC_WIDTH+1)'(-(2 ** (DATA_WIDTH - 1)));

    typedef enum logic {S_IDLE, S_ACC} state_t;

    state_t                         state_q, state_d;
    logic [TILE_W-1:0]              tile_cnt_q, tile_cnt_d;
    logic [TILE_W-1:0]              n_q, n_d;
    logic signed [ACC_WIDTH-1:0]    acc_q [LANES];
    logic signed [ACC_WIDTH-1:0]    acc_d [LANES];
    logic [DATA_WIDTH*LANES-1:0]    data_q, data_d;
    logic                           valid_q, valid_d;
    logic signed [ACC_WIDTH-1:0]    psum_ext [LANES];
    logic signed [ACC_WIDTH-1:0]    bias_ext [LANES];
    logic                           accept;
    logic                           finish;
    logic [TILE_W-1:0]              n_first;

    // Round half toward +inf, then clamp into the signed output range.
    function automatic logic [DATA_WIDTH-1:0] requant(input logic signed [ACC_WIDTH-1:0] a);
        logic signed [ACC_WIDTH:0] r;
        r = ($signed({a[ACC_WIDTH-1], a}) + HALF) >>> FRAC_BITS;
        if (r > SAT_MAX)      return SAT_MAX[DATA_WIDTH-1:0];
        else if (r < SAT_MIN) return SAT_MIN[DATA_WIDTH-1:0];
        else                  return r[DATA_WIDTH-1:0];
    endfunction

    assign in_ready = !valid_q || out_ready;
    assign accept   = in_valid && in_ready;
    assign n_first  = (cfg_num_tiles == '0) ? TILE_W'(1) : cfg_num_tiles;
    assign busy     = (state_q == S_ACC);
    assign valid    = valid_q;
    assign data_out = data_q;

    always_comb begin
        for (int i = 0; i < LANES; i++) begin
            psum_ext[i] = {{(ACC_WIDTH-PSUM_WIDTH){psum_in[i*PSUM_WIDTH+PSUM_WIDTH-1]}},
                           psum_in[i*PSUM_WIDTH +: PSUM_WIDTH]};
            bias_ext[i] = {{(ACC_WIDTH-DATA_WIDTH-FRAC_BITS){bias_in[i*DATA_WIDTH+DATA_WIDTH-1]}},
                           bias_in[i*DATA_WIDTH +: DATA_WIDTH], {FRAC_BITS{1'b0}}};
        end
    end

    always_comb begin
        state_d    = state_q;
        tile_cnt_d = tile_cnt_q;
        n_d        = n_q;
        valid_d    = valid_q;
        data_d     = data_q;
        finish     = 1'b0;
        for (int i = 0; i < LANES; i++) acc_d[i] = acc_q[i];

        if (valid_q && out_ready) valid_d = 1'b0;

        if (accept) begin
            unique case (state_q)
                S_IDLE: begin
                    n_d = n_first;
                    for (int i = 0; i < LANES; i++) acc_d[i] = psum_ext[i] + bias_ext[i];
                    if (n_first == TILE_W'(1)) begin
                        finish = 1'b1;
                    end else begin
                        tile_cnt_d = TILE_W'(1);
                        state_d    = S_ACC;
                    end
                end
                S_ACC: begin
                    for (int i = 0; i < LANES; i++) acc_d[i] = acc_q[i] + psum_ext[i];
                    if (tile_cnt_q == n_q - TILE_W'(1)) begin
                        finish     = 1'b1;
                        tile_cnt_d = '0;
                        state_d    = S_IDLE;
                    end else begin
                        tile_cnt_d = tile_cnt_q + TILE_W'(1);
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end

        // A finishing pixel wins over the drain, so a same-cycle handoff reloads.
        if (finish) begin
            valid_d = 1'b1;
            for (int i = 0; i < LANES; i++) data_d[i*DATA_WIDTH +: DATA_WIDTH] = requant(acc_d[i]);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= S_IDLE;
            tile_cnt_q <= '0;
            n_q        <= '0;
            valid_q    <= 1'b0;
            data_q     <= '0;
            for (int i = 0; i < LANES; i++) acc_q[i] <= '0;
        end else begin
            state_q    <= state_d;
            tile_cnt_q <= tile_cnt_d;
            n_q        <= n_d;
            valid_q    <= valid_d;
            data_q     <= data_d;
            for (int i = 0; i < LANES; i++) acc_q[i] <= acc_d[i];
        end
    end
endmodule

// File: tb/tb_conv2d_psum_accum_16.sv
// Bench for conv2d_psum_accum_16: directed rounding/saturation/handshake/reset steps,
// then random pixels under random backpressure checked against a per-pixel arithmetic model.
module tb_conv2d_psum_accum_16;
    logic         clk = 1'b0;
    logic         rst;
    logic [6:0]   cfg_num_tiles;
    logic         in_valid;
    logic         in_ready;
    logic [511:0] psum_in;
    logic [223:0] bias_in;
    logic [223:0] data_out;
    logic         valid;
    logic         out_ready;
    logic         busy;

    logic         or_dir;
    logic         or_rand = 1'b1;
    bit           bp_rand = 1'b0;
    assign out_ready = bp_rand ? or_rand : or_dir;

    int n_vec = 0;
    int n_err = 0;
    logic [223:0] exp_q[$];
    longint bp [0:7][0:15];
    longint bb [0:15];

    conv2d_psum_accum_16 dut (
        .clk           (clk),
        .rst           (rst),
        .cfg_num_tiles (cfg_num_tiles),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .psum_in       (psum_in),
        .bias_in       (bias_in),
        .data_out      (data_out),
        .valid         (valid),
        .out_ready     (out_ready),
        .busy          (busy)
    );

    always #5 clk = ~clk;

    always @(negedge clk) if (bp_rand) or_rand = 1'($urandom_range(0, 1));

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0d expected=%0d", tag, $signed(obs), $signed(exp));
        end
    endtask

    function automatic logic [63:0] lane(input int i);
        return 64'($signed(data_out[i*14 +: 14]));
    endfunction

    // Value = (sum of psums + bias*2^7) / 2^7, rounded half up, clamped to 14-bit signed.
    function automatic logic [13:0] ref_lane(input longint psum_sum, input longint bias);
        longint s, r;
        s = psum_sum + bias * 128 + 64;
        if (s >= 0) r = s / 128;
        else        r = -((-s + 127) / 128);
        if (r > 8191)  r = 8191;
        if (r < -8192) r = -8192;
        return 14'(r);
    endfunction

    function automatic logic [223:0] uniform_word(input longint p, input longint b);
        logic [223:0] w;
        for (int i = 0; i < 16; i++) w[i*14 +: 14] = ref_lane(p, b);
        return w;
    endfunction

    // Scoreboard: every consumed output word must match the oldest expected pixel.
    always begin
        @(negedge clk);
        #4;
        if (rst === 1'b0) begin
            n_vec++;
            assert (in_ready === (!valid || out_ready)) else begin
                n_err++;
                $error("FAIL in_ready_rule observed=%b expected=%b", in_ready, (!valid || out_ready));
            end
            if (valid === 1'b1 && out_ready === 1'b1) begin
                n_vec++;
                assert (exp_q.size() != 0) else begin
                    n_err++;
                    $error("FAIL unexpected_pixel observed=%h expected=none", data_out);
                end
                if (exp_q.size() != 0) begin
                    logic [223:0] w;
                    w = exp_q.pop_front();
                    n_vec++;
                    assert (data_out === w) else begin
                        n_err++;
                        $error("FAIL pixel_data observed=%h expected=%h", data_out, w);
                    end
                end
            end
        end
    end

    task automatic end_burst();
        in_valid = 1'b0;
        psum_in  = {16{$urandom()}};
    endtask

    // Starts and ends on a falling edge; holds the beat until the block takes it.
    task automatic send_beat();
        bit rdy = 1'b0;
        int waited = 0;
        in_valid = 1'b1;
        while (!rdy && waited < 500) begin
            #1;
            rdy = in_ready;
            @(posedge clk);
            @(negedge clk);
            waited++;
        end
        check("beat_accepted", 64'(rdy), 64'(1));
    endtask

    task automatic clear_bp();
        for (int b = 0; b < 8; b++) for (int i = 0; i < 16; i++) bp[b][i] = 0;
        for (int i = 0; i < 16; i++) bb[i] = 0;
    endtask

    task automatic run_pixel(input int cfg, input bit chk, input bit gaps);
        int n;
        longint sums [16];
        logic [223:0] w;
        n = (cfg == 0) ? 1 : cfg;
        for (int i = 0; i < 16; i++) begin
            sums[i] = 0;
            for (int b = 0; b < n; b++) sums[i] += bp[b][i];
            w[i*14 +: 14] = ref_lane(sums[i], bb[i]);
        end
        exp_q.push_back(w);
        for (int b = 0; b < n; b++) begin
            for (int i = 0; i < 16; i++) psum_in[i*32 +: 32] = 32'(bp[b][i]);
            if (b == 0) begin
                cfg_num_tiles = 7'(cfg);
                for (int i = 0; i < 16; i++) bias_in[i*14 +: 14] = 14'(bb[i]);
            end else begin
                cfg_num_tiles = 7'($urandom_range(0, 127));
                bias_in = {7{$urandom()}};
            end
            send_beat();
            if (chk) begin
                if (b < n - 1) begin
                    check("busy_mid_pixel", 64'(busy), 64'(1));
                    check("valid_mid_pixel", 64'(valid), 64'(0));
                end else begin
                    check("valid_after_last", 64'(valid), 64'(1));
                    check("busy_after_last", 64'(busy), 64'(0));
                end
            end
            if (gaps && b < n - 1 && $urandom_range(0, 2) == 0) begin
                end_burst();
                repeat ($urandom_range(1, 2)) @(negedge clk);
            end
        end
        end_burst();
    endtask

    initial begin
        rst = 1'b1;
        or_dir = 1'b1;
        in_valid = 1'b0;
        cfg_num_tiles = 7'd1;
        psum_in = '0;
        bias_in = '0;
        repeat (2) @(negedge clk);
        check("reset_valid", 64'(valid), 64'(0));
        check("reset_busy", 64'(busy), 64'(0));
        check("reset_in_ready", 64'(in_ready), 64'(1));
        check("reset_data", 64'(data_out == '0), 64'(1));
        rst = 1'b0;
        @(negedge clk);

        // Single tile with bias: (384 + 128 + 64) >> 7 = 4.
        clear_bp();
        for (int i = 0; i < 16; i++) begin bp[0][i] = 384; bb[i] = 1; end
        run_pixel(1, 1, 0);
        check("single_lane0", lane(0), 64'(4));
        check("single_lane15", lane(15), 64'(4));

        // Rounding boundaries around half an LSB.
        clear_bp();
        bp[0][0] = 64; bp[0][1] = 63; bp[0][2] = -64; bp[0][3] = -65;
        run_pixel(1, 1, 0);
        check("round_64", lane(0), 64'(1));
        check("round_63", lane(1), 64'(0));
        check("round_m64", lane(2), 64'(0));
        check("round_m65", lane(3), 64'(-1));

        // Four tiles, bias 2 on every lane: lane0 (896 + 256 + 64) >> 7 = 9, others 2.
        clear_bp();
        bp[0][0] = 128; bp[1][0] = 256; bp[2][0] = -128; bp[3][0] = 640;
        for (int i = 0; i < 16; i++) bb[i] = 2;
        run_pixel(4, 1, 0);
        check("multi_lane0", lane(0), 64'(9));
        check("multi_lane7", lane(7), 64'(2));

        // Saturation both ways.
        clear_bp();
        for (int i = 0; i < 16; i++) begin bp[0][i] = 'h80000; bp[1][i] = 'h80000; end
        run_pixel(2, 1, 0);
        check("sat_pos", lane(5), 64'(8191));
        clear_bp();
        for (int i = 0; i < 16; i++) bp[0][i] = -2000000;
        run_pixel(1, 1, 0);
        check("sat_neg", lane(9), 64'(-8192));

        // Backpressure: result pending, next beat offered but refused until release.
        @(negedge clk);
        or_dir = 1'b0;
        clear_bp();
        for (int i = 0; i < 16; i++) bp[0][i] = 1280;
        run_pixel(1, 1, 0);
        for (int i = 0; i < 16; i++) psum_in[i*32 +: 32] = 32'd2560;
        bias_in = '0;
        cfg_num_tiles = 7'd1;
        in_valid = 1'b1;
        for (int k = 0; k < 3; k++) begin
            #1;
            check("bp_in_ready_low", 64'(in_ready), 64'(0));
            @(negedge clk);
            check("bp_valid_hold", 64'(valid), 64'(1));
            check("bp_data_hold", lane(0), 64'(10));
        end
        exp_q.push_back(uniform_word(2560, 0));
        or_dir = 1'b1;
        #1;
        check("bp_in_ready_release", 64'(in_ready), 64'(1));
        @(negedge clk);
        check("reload_valid", 64'(valid), 64'(1));
        check("reload_data", lane(3), 64'(20));
        end_burst();
        @(negedge clk);
        check("drain_valid", 64'(valid), 64'(0));
        check("drain_in_ready", 64'(in_ready), 64'(1));

        // Zero tile count acts as one tile.
        clear_bp();
        for (int i = 0; i < 16; i++) begin bp[0][i] = 1000 * i - 7000; bb[i] = 5 - i; end
        run_pixel(0, 1, 0);

        // Reset in the middle of a four-tile pixel discards it.
        clear_bp();
        for (int i = 0; i < 16; i++) begin psum_in[i*32 +: 32] = 32'd100000; bias_in[i*14 +: 14] = 14'd50; end
        cfg_num_tiles = 7'd4;
        send_beat();
        send_beat();
        end_burst();
        rst = 1'b1;
        #1;
        check("midrst_valid", 64'(valid), 64'(0));
        check("midrst_busy", 64'(busy), 64'(0));
        check("midrst_data", 64'(data_out == '0), 64'(1));
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        for (int i = 0; i < 16; i++) begin bp[0][i] = 300 * i; bp[1][i] = -77 * i; bb[i] = 3; end
        run_pixel(2, 1, 0);
        check("fresh_lane0", lane(0), 64'(3));

        // Random pixels under random output backpressure.
        bp_rand = 1'b1;
        for (int p = 0; p < 40; p++) begin
            longint amp;
            clear_bp();
            amp = ($urandom_range(0, 3) == 0) ? (64'sd1 << 26) : (64'sd1 << 18);
            for (int b = 0; b < 8; b++)
                for (int i = 0; i < 16; i++)
                    bp[b][i] = longint'($urandom_range(0, 32'(2 * amp))) - amp;
            for (int i = 0; i < 16; i++) bb[i] = longint'($urandom_range(0, 16383)) - 8192;
            run_pixel($urandom_range(0, 6), 0, 1);
        end
        bp_rand = 1'b0;
        or_dir = 1'b1;
        for (int k = 0; k < 50 && exp_q.size() != 0; k++) @(negedge clk);
        check("all_pixels_seen", 64'(exp_q.size()), 64'(0));
        @(negedge clk);
        check("final_valid", 64'(valid), 64'(0));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
